seg_scan_controller: RTL

- Time-multiplexing controller for the 4-digit common-anode seven-segment display.
- Generates the 2-bit digit index (refresh_count) and the active-low anode and cathode patterns.
- Inserts a guard blanking interval at each digit change to suppress ghosting.
- Double-buffers the displayed 16-bit hex value so updates land only on frame boundaries.

---
 rtl/seg_scan_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// Four-digit common-anode seven-segment scan controller with per-slot guard blanking
// and a frame-synchronous double-buffered display value. Optional macro: SEG_LZ_BLANK_EN.
module seg_scan_controller #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic        value_load,
    output logic        pending,
    output logic [1:0]  refresh_count,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        frame_tick
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;
    localparam logic [0:0] ST_RESET = (GUARD_CYCLES == 0) ? ST_SHOW : ST_GUARD;

    logic [CW-1:0] slot_cnt, slot_nxt;
    logic [1:0]    digit, digit_nxt;
    logic [0:0]    state, state_nxt;
    logic [15:0]   active, active_nxt;
    logic [15:0]   shadow, shadow_nxt;
    logic          pending_nxt;
    logic          enable_q;
    logic          wrap;
    logic          lz_blank;
    logic          show;
    logic [3:0]    nibble;
    logic [3:0]    anode_nxt;
    logic [6:0]    cathode_nxt;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: hex_decode = 7'b1000000;
            4'h1: hex_decode = 7'b1111001;
            4'h2: hex_decode = 7'b0100100;
            4'h3: hex_decode = 7'b0110000;
            4'h4: hex_decode = 7'b0011001;
            4'h5: hex_decode = 7'b0010010;
            4'h6: hex_decode = 7'b0000010;
            4'h7: hex_decode = 7'b1111000;
            4'h8: hex_decode = 7'b0000000;
            4'h9: hex_decode = 7'b0010000;
            4'hA: hex_decode = 7'b0001000;
            4'hB: hex_decode = 7'b0000011;
            4'hC: hex_decode = 7'b1000110;
            4'hD: hex_decode = 7'b0100001;
            4'hE: hex_decode = 7'b0000110;
            default: hex_decode = 7'b0001110;
        endcase
    endfunction

    // Re-enabling restarts the current digit's slot so it always begins with a guard interval.
    always_comb begin
        slot_nxt  = slot_cnt;
        digit_nxt = digit;
        wrap      = 1'b0;
        if (enable) begin
            if (!enable_q) begin
                slot_nxt = '0;
            end else if (slot_cnt == SLOT_LAST) begin
                slot_nxt  = '0;
                digit_nxt = digit + 2'd1;
                wrap      = (digit == 2'd3);
            end else begin
                slot_nxt = slot_cnt + 1'b1;
            end
        end
        state_nxt = (slot_nxt < GUARD_END) ? ST_GUARD : ST_SHOW;
    end

    // A load coinciding with the wrap goes straight to the display instead of waiting a frame.
    always_comb begin
        active_nxt  = active;
        shadow_nxt  = shadow;
        pending_nxt = pending;
        if (wrap) begin
            if (value_load) begin
                active_nxt  = value_in;
                shadow_nxt  = value_in;
                pending_nxt = 1'b0;
            end else if (pending) begin
                active_nxt  = shadow;
                pending_nxt = 1'b0;
            end
        end else if (value_load) begin
            shadow_nxt  = value_in;
            pending_nxt = 1'b1;
        end
    end

    always_comb begin
        nibble = active_nxt[{digit_nxt, 2'b00} +: 4];
`ifdef SEG_LZ_BLANK_EN
        case (digit_nxt)
            2'd1:    lz_blank = (active_nxt[15:4] == 12'h000);
            2'd2:    lz_blank = (active_nxt[15:8] == 8'h00);
            2'd3:    lz_blank = (active_nxt[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
        show        = enable && (state_nxt == ST_SHOW) && !lz_blank;
        anode_nxt   = show ? ~(4'b0001 << digit_nxt) : 4'b1111;
        cathode_nxt = show ? hex_decode(nibble) : 7'b1111111;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt      <= '0;
            digit         <= 2'd0;
            state         <= ST_RESET;
            active        <= 16'h0000;
            shadow        <= 16'h0000;
            pending       <= 1'b0;
            enable_q      <= 1'b1;
            refresh_count <= 2'd0;
            anode         <= 4'b1111;
            cathode       <= 7'b1111111;
            frame_tick    <= 1'b0;
        end else begin
            slot_cnt      <= slot_nxt;
            digit         <= digit_nxt;
            state         <= state_nxt;
            active        <= active_nxt;
            shadow        <= shadow_nxt;
            pending       <= pending_nxt;
            enable_q      <= enable;
            refresh_count <= digit_nxt;
            anode         <= anode_nxt;
            cathode       <= cathode_nxt;
            frame_tick    <= wrap;
        end
    end

endmodule
